// File: rtl/n64_crc_checker.sv
// n64_crc_checker: serial receive-side CRC-8 checker for a fixed-length
// accessory data block followed by one CRC byte. Completed data bytes are
// presented in parallel for downstream pak-memory writes.
module n64_crc_checker #(
    parameter int          BYTES = 32,
    parameter int          IDX_W = 5,
    parameter logic [7:0]  POLY  = 8'h85
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic             data,
    output logic             busy,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    output logic [IDX_W-1:0] byte_index,
    output logic             done,
    output logic             crc_ok,
    output logic [7:0]       crc_calc,
    output logic [7:0]       crc_rx
);

    localparam int DATA_BITS = BYTES * 8;
    // Counter only ever holds 0..DATA_BITS-1, so it never needs the extra bit.
    localparam int CNT_W     = (DATA_BITS > 8) ? $clog2(DATA_BITS) : 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CRC    = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [7:0]       rem_reg;
    logic [6:0]       shift_reg;
    logic [7:0]       crc_rx_reg;
    logic [7:0]       byte_data_reg;
    logic [IDX_W-1:0] byte_cnt_reg;
    logic [IDX_W-1:0] byte_index_reg;
    logic             byte_valid_reg;
    logic             crc_ok_reg;

    logic             accept_start;
    logic             take_data;
    logic             take_crc;
    logic             last_data_bit;
    logic             last_crc_bit;
    logic             byte_end;
    logic             fb;
    logic [7:0]       rem_next;
    logic [7:0]       shift_next;
    logic [7:0]       crc_rx_next;

    assign accept_start  = (state_reg == IDLE) && start;
    assign take_data     = (state_reg == DATA) && enable;
    assign take_crc      = (state_reg == CRC) && enable;
    assign last_data_bit = (bit_cnt_reg == CNT_W'(DATA_BITS - 1));
    assign last_crc_bit  = (bit_cnt_reg[2:0] == 3'd7);
    assign byte_end      = (bit_cnt_reg[2:0] == 3'd7);

    // Direct-form CRC: feedback mixes the incoming bit with the remainder MSB,
    // so no trailing zero bits are needed to flush the register.
    assign fb          = data ^ rem_reg[7];
    assign rem_next    = {rem_reg[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    assign shift_next  = {shift_reg, data};
    assign crc_rx_next = {crc_rx_reg[6:0], data};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-derived status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (enable && last_data_bit) begin
                    state_next = CRC;
                end
            end
            CRC: begin
                busy = 1'b1;
                if (enable && last_crc_bit) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: remainder, byte assembly, received CRC capture and verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_reg    <= '0;
            rem_reg        <= 8'h00;
            shift_reg      <= 7'h00;
            crc_rx_reg     <= 8'h00;
            byte_data_reg  <= 8'h00;
            byte_cnt_reg   <= '0;
            byte_index_reg <= '0;
            byte_valid_reg <= 1'b0;
            crc_ok_reg     <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (accept_start) begin
                bit_cnt_reg    <= '0;
                rem_reg        <= 8'h00;
                shift_reg      <= 7'h00;
                crc_rx_reg     <= 8'h00;
                byte_cnt_reg   <= '0;
                byte_index_reg <= '0;
                crc_ok_reg     <= 1'b0;
            end
            if (take_data) begin
                rem_reg     <= rem_next;
                shift_reg   <= shift_next[6:0];
                bit_cnt_reg <= last_data_bit ? '0 : bit_cnt_reg + CNT_W'(1);
                if (byte_end) begin
                    byte_data_reg  <= shift_next;
                    byte_valid_reg <= 1'b1;
                    byte_index_reg <= byte_cnt_reg;
                    // Saturate so the counter never wraps past the last byte.
                    if (byte_cnt_reg != IDX_W'(BYTES - 1)) begin
                        byte_cnt_reg <= byte_cnt_reg + IDX_W'(1);
                    end
                end
            end
            if (take_crc) begin
                crc_rx_reg  <= crc_rx_next;
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                if (last_crc_bit) begin
                    crc_ok_reg <= (rem_reg == crc_rx_next);
                end
            end
        end
    end

    // rem only moves in DATA, so crc_calc freezes once the CRC byte begins.
    assign crc_calc   = rem_reg;
    assign crc_rx     = crc_rx_reg;
    assign crc_ok     = crc_ok_reg;
    assign byte_data  = byte_data_reg;
    assign byte_index = byte_index_reg;
    assign byte_valid = byte_valid_reg;

endmodule

// File: tb/tb_n64_crc_checker.sv
// Testbench for n64_crc_checker: randomized frames on a 32-byte and a 1-byte
// instance, expected bytes/results queued by the driver and consumed by
// per-instance monitors.
module tb_n64_crc_checker;

    localparam logic [7:0] POLY = 8'h85;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, en0, d0, busy0, bv0, done0, ok0;
    logic [7:0] bd0, calc0, rx0;
    logic [4:0] bi0;
    logic       start1, en1, d1, busy1, bv1, done1, ok1;
    logic [7:0] bd1, calc1, rx1;
    logic [0:0] bi1;

    n64_crc_checker #(.BYTES(32), .IDX_W(5), .POLY(POLY)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .enable(en0), .data(d0),
        .busy(busy0), .byte_valid(bv0), .byte_data(bd0), .byte_index(bi0),
        .done(done0), .crc_ok(ok0), .crc_calc(calc0), .crc_rx(rx0)
    );

    n64_crc_checker #(.BYTES(1), .IDX_W(1), .POLY(POLY)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .enable(en1), .data(d1),
        .busy(busy1), .byte_valid(bv1), .byte_data(bd1), .byte_index(bi1),
        .done(done1), .crc_ok(ok1), .crc_calc(calc1), .crc_rx(rx1)
    );

    typedef struct {
        logic [7:0] d;
        int         idx;
    } byte_t;

    typedef struct {
        logic [7:0] calc;
        logic [7:0] rx;
        logic       ok;
        int         start_edge;
        int         lat;
    } res_t;

    byte_t eb0[$];
    byte_t eb1[$];
    res_t  er0[$];
    res_t  er1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: generate_crc style long division of message * x^8 by POLY.
    function automatic logic [7:0] crc8_ref(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic [7:0] m;
        logic       top;
        r = 8'h00;
        for (int i = 0; i <= msg.size(); i++) begin
            m = (i < msg.size()) ? msg[i] : 8'h00;
            for (int j = 7; j >= 0; j--) begin
                top = r[7];
                r   = {r[6:0], m[j]};
                if (top) r = r ^ POLY;
            end
        end
        return r;
    endfunction

    // Monitor: compares every byte_valid and done against the queued expectations.
    task automatic mon_step(input int w, input logic bv, input logic [7:0] bd, input logic [31:0] bi,
                            input logic dn, input logic bz, input logic [7:0] calc,
                            input logic [7:0] rx, input logic ok);
        byte_t b;
        res_t  r;
        int    qs;
        if (bv) begin
            qs = (w == 0) ? eb0.size() : eb1.size();
            if (qs == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_byte_valid dut%0d: got byte %0h expected no pulse", w, bd);
            end else begin
                b = (w == 0) ? eb0.pop_front() : eb1.pop_front();
                check($sformatf("byte_data dut%0d idx%0d", w, b.idx), 32'(bd), 32'(b.d));
                check($sformatf("byte_index dut%0d", w), bi, 32'(b.idx));
            end
        end
        if (dn) begin
            qs = (w == 0) ? er0.size() : er1.size();
            if (qs == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done dut%0d: got done=1 expected 0", w);
            end else begin
                r = (w == 0) ? er0.pop_front() : er1.pop_front();
                check($sformatf("crc_calc dut%0d", w), 32'(calc), 32'(r.calc));
                check($sformatf("crc_rx dut%0d", w), 32'(rx), 32'(r.rx));
                check($sformatf("crc_ok dut%0d", w), 32'(ok), 32'(r.ok));
                check($sformatf("busy_at_done dut%0d", w), 32'(bz), 32'd0);
                if (r.lat >= 0)
                    check($sformatf("done_latency dut%0d", w), 32'(edge_cnt - r.start_edge), 32'(r.lat));
                $display("frame dut%0d: calc=%02h rx=%02h ok=%0b", w, calc, rx, ok);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_step(0, bv0, bd0, 32'(bi0), done0, busy0, calc0, rx0, ok0);
            mon_step(1, bv1, bd1, 32'(bi1), done1, busy1, calc1, rx1, ok1);
        end
    end

    task automatic set_in(input int w, input logic s, input logic e, input logic d);
        if (w == 0) begin start0 = s; en0 = e; d0 = d; end
        else        begin start1 = s; en1 = e; d1 = d; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int w, input logic b, input int max_gap, input logic s);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            set_in(w, 1'b0, 1'b0, 1'($urandom));
            tick();
        end
        set_in(w, s, 1'b1, b);
        tick();
        set_in(w, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input int w);
        if (w == 0) begin
            check("rst busy0", 32'(busy0), 0);  check("rst byte_valid0", 32'(bv0), 0);
            check("rst byte_data0", 32'(bd0), 0); check("rst byte_index0", 32'(bi0), 0);
            check("rst done0", 32'(done0), 0);  check("rst crc_ok0", 32'(ok0), 0);
            check("rst crc_calc0", 32'(calc0), 0); check("rst crc_rx0", 32'(rx0), 0);
        end else begin
            check("rst busy1", 32'(busy1), 0);  check("rst byte_valid1", 32'(bv1), 0);
            check("rst byte_data1", 32'(bd1), 0); check("rst byte_index1", 32'(bi1), 0);
            check("rst done1", 32'(done1), 0);  check("rst crc_ok1", 32'(ok1), 0);
            check("rst crc_calc1", 32'(calc1), 0); check("rst crc_rx1", 32'(rx1), 0);
        end
    endtask

    task automatic wait_drain(input int w);
        for (int k = 0; k < 20; k++) begin
            if (w == 0 && eb0.size() == 0 && er0.size() == 0) break;
            if (w == 1 && eb1.size() == 0 && er1.size() == 0) break;
            tick();
        end
        check($sformatf("pending_bytes dut%0d", w), (w == 0) ? eb0.size() : eb1.size(), 0);
        check($sformatf("pending_results dut%0d", w), (w == 0) ? er0.size() : er1.size(), 0);
    endtask

    // Full frame: start (with an ignored enable), data bits, CRC bits, then
    // enable strobes that land in RESULT/IDLE and must be ignored.
    task automatic run_frame(input int w, input logic [7:0] msg[$], input logic [7:0] crc,
                             input int max_gap, input int mid_start_bit, input bit chk_lat);
        res_t       r;
        byte_t      b;
        logic [7:0] cur;
        int         nbits;
        nbits = msg.size() * 8;
        r.calc = crc8_ref(msg);
        r.rx   = crc;
        r.ok   = (r.calc == crc);
        r.lat  = chk_lat ? nbits + 8 : -1;
        for (int i = 0; i < msg.size(); i++) begin
            b.d = msg[i];
            b.idx = i;
            if (w == 0) eb0.push_back(b); else eb1.push_back(b);
        end
        set_in(w, 1'b1, 1'b1, 1'($urandom));
        r.start_edge = edge_cnt + 1;
        if (w == 0) er0.push_back(r); else er1.push_back(r);
        tick();
        for (int i = 0; i < nbits + 8; i++) begin
            cur = (i < nbits) ? msg[i / 8] : crc;
            drive_bit(w, cur[7 - (i % 8)], max_gap, i == mid_start_bit);
        end
        repeat (3) begin
            set_in(w, 1'b0, 1'b1, 1'($urandom));
            tick();
        end
        set_in(w, 1'b0, 1'b0, 1'b0);
        wait_drain(w);
    endtask

    initial begin
        logic [7:0] msg[$];
        logic [7:0] c;

        reset = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_zero(0);
        check_zero(1);
        reset = 1'b0;
        tick();

        // All-zero block, CRC 00, continuous enable.
        msg = {};
        for (int i = 0; i < 32; i++) msg.push_back(8'h00);
        run_frame(0, msg, 8'h00, 0, -1, 1'b1);

        // Single-byte frames.
        msg = {8'h01};
        run_frame(1, msg, 8'h85, 0, -1, 1'b1);
        msg = {8'h02};
        run_frame(1, msg, 8'h8F, 0, -1, 1'b1);

        // Trailing 01 with a wrong CRC byte.
        msg = {};
        for (int i = 0; i < 31; i++) msg.push_back(8'h00);
        msg.push_back(8'h01);
        run_frame(0, msg, 8'h84, 0, -1, 1'b1);

        // Random data, random gaps, stray start mid-frame; then gap-free repeat.
        for (int t = 0; t < 3; t++) begin
            msg = {};
            for (int i = 0; i < 32; i++) msg.push_back(8'($urandom));
            c = crc8_ref(msg);
            run_frame(0, msg, c, 5, int'($urandom_range(263, 1)), 1'b0);
            run_frame(0, msg, c, 0, -1, 1'b1);
        end

        // Reset after 100 data bits: 12 complete bytes, no done.
        msg = {};
        for (int i = 0; i < 32; i++) msg.push_back(8'($urandom));
        for (int i = 0; i < 12; i++) begin
            byte_t b;
            b.d = msg[i];
            b.idx = i;
            eb0.push_back(b);
        end
        set_in(0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 100; i++) begin
            c = msg[i / 8];
            drive_bit(0, c[7 - (i % 8)], 0, 1'b0);
        end
        reset = 1'b1;
        tick();
        check_zero(0);
        check("after_reset pending_bytes", eb0.size(), 0);
        reset = 1'b0;
        tick();
        run_frame(0, msg, crc8_ref(msg), 2, -1, 1'b0);

        // Random corrupted CRC bytes on both instances.
        for (int t = 0; t < 2; t++) begin
            msg = {};
            for (int i = 0; i < 32; i++) msg.push_back(8'($urandom));
            c = crc8_ref(msg) ^ 8'($urandom_range(255, 1));
            run_frame(0, msg, c, 1, -1, 1'b0);
        end
        for (int t = 0; t < 6; t++) begin
            msg = {8'($urandom)};
            c = (t % 2 == 0) ? crc8_ref(msg) : 8'($urandom);
            run_frame(1, msg, c, 3, int'($urandom_range(15, 1)), 1'b0);
        end

        repeat (5) tick();
        check("final queue eb0", eb0.size(), 0);
        check("final queue er0", er0.size(), 0);
        check("final queue eb1", eb1.size(), 0);
        check("final queue er1", er1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/n64_crc_checker.md
# n64_crc_checker

Serial receive-side companion to `generate_crc` for the fake N64 accessory path. It accepts an MSB-first bit stream made of a fixed-length data block followed by one CRC-8 byte. It recomputes the CRC over the data bits, captures the received CRC byte and reports match or mismatch. Data bytes are presented in parallel as they complete, for downstream pak-memory writes.

## Interface
Parameters:
- `BYTES`, default 32: data bytes per frame, matching an N64 pak block; legal range 1..256.
- `IDX_W`, default 5: width of `byte_index`; must satisfy 2^IDX_W >= BYTES.
- `POLY`, default 8'h85: CRC-8 polynomial with the x^8 term implied.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new frame; honoured only in IDLE.
- `enable` in 1: bit strobe; `data` is sampled on every clk edge where `enable`=1 in DATA or CRC state.
- `data` in 1: serial bit, MSB of each byte first.
- `busy` out 1: high in DATA and CRC states.
- `byte_valid` out 1: one-cycle pulse when a data byte completes.
- `byte_data` out 8: the completed data byte; valid while `byte_valid`=1 and held afterwards.
- `byte_index` out IDX_W: index of the completed byte, 0..BYTES-1.
- `done` out 1: one-cycle pulse at end of frame.
- `crc_ok` out 1: result of the last frame; held until the next accepted `start`.
- `crc_calc` out 8: CRC computed over the data bits.
- `crc_rx` out 8: CRC byte received.

## Operation
- States: IDLE, DATA, CRC, RESULT.
- IDLE -> DATA on `start`=1. On that edge `rem`, `bit_cnt`, `byte_index`, `crc_rx` and `crc_ok` clear to 0. `enable` in the same cycle as `start` is ignored.
- In DATA, each accepted bit does the following:
  - `fb = data ^ rem[7]`.
  - `rem <= {rem[6:0],1'b0} ^ (fb ? POLY : 8'h00)`.
  - The bit shifts into the byte shift register LSB.
  - This is the direct form: the result equals `generate_crc` fed the same data plus 8 appended zeros.
- After every 8th DATA bit, on the next edge:
  - `byte_data` takes the assembled byte.
  - `byte_valid` pulses.
  - `byte_index` reports that byte's index and then increments.
- After bit BYTES*8 the state moves to CRC; `crc_calc` is `rem`, frozen from this point.
- In CRC, 8 accepted bits shift MSB-first into `crc_rx`. After the 8th bit the state moves to RESULT.
- RESULT lasts one cycle: `done`=1, `crc_ok = (crc_calc == crc_rx)`, then IDLE.
- `start` is ignored outside IDLE, including in RESULT.
- `enable` is ignored in IDLE and RESULT.
- Gaps of any length between `enable` strobes are allowed; no timeout.
- `bit_cnt` width is sized for BYTES*8 (11 bits for BYTES=256). The byte counter saturates at BYTES-1 and does not wrap.

## Timing
- Reset values: state IDLE and all outputs 0 (`busy`, `byte_valid`, `byte_data`, `byte_index`, `done`, `crc_ok`, `crc_calc`, `crc_rx`).
- Reset mid-frame: on the next edge the block returns to IDLE with all outputs 0. No `done` or `byte_valid` is emitted for the partial frame.
- `busy` rises the cycle after `start` is sampled. It falls the same edge that `done` rises.
- `byte_valid` for byte k is asserted in the cycle after the edge that sampled that byte's last bit. There is one pulse per byte even under back-to-back strobes.
- `done` is asserted in the cycle after the edge that sampled the last CRC bit, which is the RESULT state.
- With continuous `enable`, the frame takes (BYTES+1)*8 cycles after the `start` edge, plus 1 cycle for RESULT.
- The last data byte's `byte_valid` occurs in the same cycle as the first CRC-state cycle.
- `crc_ok`, `crc_calc` and `crc_rx` are stable from `done` until the next accepted `start`.

## Test plan
- BYTES=32, all-zero data, CRC byte 8'h00, continuous `enable` -> 32 `byte_valid` pulses with `byte_data`=00 and `byte_index` 0..31. Then `done` at cycle 265 after `start` with `crc_calc`=00 and `crc_ok`=1.
- BYTES=1, data 8'h01, CRC 8'h85 -> `crc_calc`=85, `crc_rx`=85, `crc_ok`=1. Repeat with data 8'h02 and CRC 8'h8F -> `crc_ok`=1.
- BYTES=32, bytes 0..30 = 00, byte 31 = 01, CRC 8'h84 -> `crc_calc`=85, `crc_rx`=84, `crc_ok`=0, `done` pulses once.
- Random gaps of 0-5 cycles between `enable` strobes, with `start` pulsed mid-frame -> the extra `start` is ignored, and the result equals the gap-free run.
- Assert `reset` after 100 DATA bits -> the next cycle is IDLE with all outputs 0 and no `done`. A following clean frame then passes.
- Cross-check against `generate_crc`: feed the same 32 random bytes plus 8 zeros to `generate_crc` and use its `rem` as the CRC byte -> `crc_ok`=1.
